// File: rtl/dna_serial_desc_if.sv
// Byte-stream and request bundle between the control-endpoint responder and
// the DNA serial-number descriptor source.
interface dna_serial_desc_if;
    logic        req;
    logic [15:0] req_len;
    logic        abort;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    // Descriptor source side.
    modport slave (
        input  req, req_len, abort, out_ready,
        output out_data, out_valid, out_last, busy, done
    );

    // Responder side: issues requests and consumes bytes.
    modport master (
        output req, req_len, abort, out_ready,
        input  out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/dna_serial_desc.sv
// Serves the latched 57-bit device DNA as a USB string descriptor:
// 15 hex digits in UTF-16LE, 32 bytes total, truncated to the host wLength.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; waiting for req
// WAIT  | request accepted before the DNA latch is valid
// SEND  | streaming descriptor bytes, out_valid held high
module dna_serial_desc #(
    parameter logic [7:0] DESC_TYPE = 8'h03,
    parameter bit         LOWERCASE = 1'b0
) (
    input  logic                  clk_48,
    input  logic                  rst_n,
    input  logic [56:0]           dna,
    input  logic                  dna_ready,
    dna_serial_desc_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t      state, state_nxt;
    logic [56:0] dna_q;
    logic        dna_vld;
    logic [4:0]  idx, idx_nxt;
    logic [5:0]  len_q, len_nxt, req_l;
    logic [7:0]  data_nxt;
    logic        valid_nxt, last_nxt, done_nxt;

    // Byte i of the descriptor. Digit k is nibble (14-k) of {3'b000, d}, so
    // the shift from the LSB is 56-4k; (i-2)>>1 == i[4:1]-1 for even i >= 2.
    function automatic logic [7:0] desc_byte(input logic [4:0] i, input logic [56:0] d);
        logic [59:0] v;
        logic [3:0]  k;
        logic [5:0]  sh;
        logic [3:0]  nib;
        logic [7:0]  base;
        v    = {3'b000, d};
        k    = i[4:1] - 4'd1;
        sh   = 6'd56 - {k, 2'b00};
        nib  = 4'(v >> sh);
        base = LOWERCASE ? 8'h61 : 8'h41;
        if (i == 5'd0)
            desc_byte = 8'd32;
        else if (i == 5'd1)
            desc_byte = DESC_TYPE;
        else if (i[0])
            desc_byte = 8'h00;
        else if (nib < 4'd10)
            desc_byte = 8'h30 + {4'h0, nib};
        else
            desc_byte = base + {4'h0, nib} - 8'd10;
    endfunction

    // Clamp wLength to the descriptor size with a full 16-bit compare.
    always_comb begin
        req_l = (bus.req_len > 16'd32) ? 6'd32 : bus.req_len[5:0];
    end

    // Capture the DNA once per reset, on the first cycle it is reported ready.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            dna_q   <= 57'd0;
            dna_vld <= 1'b0;
        end else if (dna_ready && !dna_vld) begin
            dna_q   <= dna;
            dna_vld <= 1'b1;
        end
    end

    // Next state, byte index and the registered output values.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (req_l == 6'd0) begin
                        done_nxt = 1'b1;
                    end else begin
                        len_nxt   = req_l;
                        idx_nxt   = 5'd0;
                        state_nxt = dna_vld ? SEND : WAIT;
                    end
                end
            end
            WAIT: begin
                if (dna_vld) begin
                    state_nxt = SEND;
                    idx_nxt   = 5'd0;
                end
            end
            SEND: begin
                if (bus.out_valid && bus.out_ready) begin
                    if (bus.out_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous req.
        if (bus.abort) begin
            state_nxt = IDLE;
            idx_nxt   = 5'd0;
            done_nxt  = 1'b0;
        end

        valid_nxt = (state_nxt == SEND);
        data_nxt  = valid_nxt ? desc_byte(idx_nxt, dna_q) : 8'h00;
        last_nxt  = valid_nxt && ({1'b0, idx_nxt} == (len_nxt - 6'd1));
    end

    // State and output registers; outputs clear asynchronously on reset.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= 5'd0;
            len_q         <= 6'd0;
            bus.out_data  <= 8'h00;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            len_q         <= len_nxt;
            bus.out_data  <= data_nxt;
            bus.out_valid <= valid_nxt;
            bus.out_last  <= last_nxt;
            bus.busy      <= (state_nxt != IDLE);
            bus.done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dna_serial_desc.sv
// Directed-plus-random bench for dna_serial_desc; expected bytes come from an
// arithmetic model of the descriptor text.
module tb_dna_serial_desc;

    logic        clk_48 = 1'b0;
    logic        rst_n;
    logic [56:0] dna, dna2;
    logic        dna_ready, dna_ready2;
    int          checks = 0;
    int          errors = 0;

    dna_serial_desc_if bus();
    dna_serial_desc_if bus2();

    dna_serial_desc #(.DESC_TYPE(8'h03), .LOWERCASE(1'b0)) dut (
        .clk_48    (clk_48),
        .rst_n     (rst_n),
        .dna       (dna),
        .dna_ready (dna_ready),
        .bus       (bus)
    );

    dna_serial_desc #(.DESC_TYPE(8'h03), .LOWERCASE(1'b1)) dut_lc (
        .clk_48    (clk_48),
        .rst_n     (rst_n),
        .dna       (dna2),
        .dna_ready (dna_ready2),
        .bus       (bus2)
    );

    always #5 clk_48 = ~clk_48;

    // Descriptor byte i for value d: hex digit k taken by integer division.
    function automatic logic [7:0] exp_byte(input logic [56:0] d, input int i, input bit lc);
        longint unsigned v, n;
        int k;
        if (i == 0) return 8'd32;
        if (i == 1) return 8'h03;
        if (i % 2 == 1) return 8'h00;
        k = (i - 2) / 2;
        v = 64'(d);
        n = (v / (64'd1 << (4 * (14 - k)))) % 64'd16;
        if (n < 10) return 8'(64'd48 + n);
        return 8'((lc ? 64'd97 : 64'd65) + n - 64'd10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_48);
        #1;
    endtask

    task automatic issue_req(input int len);
        bus.req     = 1'b1;
        bus.req_len = 16'(len);
        step();
        bus.req     = 1'b0;
        bus.req_len = 16'h0000;
    endtask

    // Accept bytes first..stop-1 of a transfer of length len; checks every
    // byte, out_last, stall stability and, if the transfer ends, the done pulse.
    task automatic drain(input logic [56:0] d, input int first, input int stop,
                         input int len, input bit rnd);
        int         idx = first;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] hd = 8'h00;
        logic       hl = 1'b0;
        while (idx < stop && cyc < 3000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data",  32'(bus.out_data),  32'(hd));
                check("hold_last",  32'(bus.out_last),  32'(hl));
            end
            stalled = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("byte%0d", idx), 32'(bus.out_data), 32'(exp_byte(d, idx, 1'b0)));
                check($sformatf("last%0d", idx), 32'(bus.out_last), 32'(idx == len - 1));
                check("busy_send", 32'(bus.busy), 32'd1);
                idx++;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                hd = bus.out_data;
                hl = bus.out_last;
            end
            step();
            cyc++;
        end
        if (idx < stop) check("timeout", 32'(idx), 32'(stop));
        if (stop == len) begin
            check("end_valid", 32'(bus.out_valid), 32'd0);
            check("end_done",  32'(bus.done),      32'd1);
            check("end_busy",  32'(bus.busy),      32'd0);
            step();
            check("done_once", 32'(bus.done),      32'd0);
        end
    endtask

    initial begin
        logic [56:0] d, dnb, dnc;
        logic [7:0]  lc_b [32];
        int          len, lim, cnt, n, cyc;

        rst_n       = 1'b1;
        dna         = 57'd0;
        dna_ready   = 1'b0;
        dna2        = 57'h0_00000000000ABF;
        dna_ready2  = 1'b1;
        bus.req = 1'b0;  bus.req_len = 16'h0;  bus.abort = 1'b0;  bus.out_ready = 1'b1;
        bus2.req = 1'b0; bus2.req_len = 16'h0; bus2.abort = 1'b0; bus2.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        step();

        // Reset values.
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_last",  32'(bus.out_last),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);

        // Full read of the reference value.
        d         = 57'h1_23456789ABCDEF;
        dna       = d;
        dna_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        step();
        issue_req(255);
        check("latency", 32'(bus.out_valid), 32'd1);
        drain(d, 0, 32, 32, 1'b0);

        // Truncation to 4 bytes.
        issue_req(4);
        drain(d, 0, 4, 4, 1'b0);

        // Empty request.
        issue_req(0);
        check("empty_valid", 32'(bus.out_valid), 32'd0);
        check("empty_done",  32'(bus.done),      32'd1);
        check("empty_busy",  32'(bus.busy),      32'd0);
        step();
        check("empty_done_once", 32'(bus.done), 32'd0);

        // Backpressure on a full read.
        issue_req(32);
        drain(d, 0, 32, 32, 1'b1);

        // Random lengths with backpressure.
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 40);
            lim = (len > 32) ? 32 : len;
            issue_req(len);
            check("rnd_latency", 32'(bus.out_valid), 32'd1);
            drain(d, 0, lim, lim, 1'b1);
        end

        // Abort after 5 bytes, then restart.
        issue_req(32);
        drain(d, 0, 5, 32, 1'b0);
        bus.out_ready = 1'b0;
        bus.abort     = 1'b1;
        step();
        bus.abort     = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy",  32'(bus.busy),      32'd0);
        check("abort_done",  32'(bus.done),      32'd0);
        step();
        check("abort_done2", 32'(bus.done),      32'd0);
        issue_req(32);
        drain(d, 0, 32, 32, 1'b0);

        // req and abort together: abort wins.
        bus.req = 1'b1; bus.req_len = 16'd32; bus.abort = 1'b1;
        step();
        bus.req = 1'b0; bus.req_len = 16'h0;  bus.abort = 1'b0;
        check("ra_valid", 32'(bus.out_valid), 32'd0);
        check("ra_busy",  32'(bus.busy),      32'd0);
        step();
        check("ra_done",  32'(bus.done),      32'd0);

        // A req during SEND must not change the transfer.
        issue_req(8);
        drain(d, 0, 2, 8, 1'b0);
        bus.out_ready = 1'b0;
        bus.req = 1'b1; bus.req_len = 16'd32;
        step();
        bus.req = 1'b0; bus.req_len = 16'h0;
        drain(d, 2, 8, 8, 1'b0);

        // Reset mid-SEND, then re-capture a new value.
        issue_req(32);
        drain(d, 0, 3, 32, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy",  32'(bus.busy),      32'd0);
        check("arst_last",  32'(bus.out_last),  32'd0);
        check("arst_data",  32'(bus.out_data),  32'd0);
        dnb = 57'({$urandom(), $urandom()});
        dna = dnb;
        step();
        rst_n = 1'b1;
        step();
        step();
        issue_req(32);
        check("recap_latency", 32'(bus.out_valid), 32'd1);
        drain(dnb, 0, 32, 32, 1'b1);

        // Request before the DNA is available.
        rst_n     = 1'b0;
        dna_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        issue_req(32);
        for (int w = 0; w < 3; w++) begin
            check("wait_busy",  32'(bus.busy),      32'd1);
            check("wait_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        dnc       = 57'({$urandom(), $urandom()});
        dna       = dnc;
        dna_ready = 1'b1;
        cnt = 0;
        while (!bus.out_valid && cnt < 3) begin
            step();
            cnt++;
        end
        check("wake_valid", 32'(bus.out_valid), 32'd1);
        check("wake_le2",   32'(cnt <= 2),      32'd1);
        drain(dnc, 0, 32, 32, 1'b1);

        // Lowercase instance.
        bus2.req = 1'b1; bus2.req_len = 16'd32;
        step();
        bus2.req = 1'b0; bus2.req_len = 16'h0;
        n = 0;
        cyc = 0;
        while (n < 32 && cyc < 200) begin
            if (bus2.out_valid) begin
                lc_b[n] = bus2.out_data;
                check($sformatf("lc_byte%0d", n), 32'(bus2.out_data), 32'(exp_byte(dna2, n, 1'b1)));
                check($sformatf("lc_last%0d", n), 32'(bus2.out_last), 32'(n == 31));
                n++;
            end
            step();
            cyc++;
        end
        check("lc_count", 32'(n), 32'd32);
        if (n == 32) begin
            check("lc_digit0", 32'(lc_b[2]),  32'h30);
            check("lc_d12",    32'(lc_b[26]), 32'h61);
            check("lc_d13",    32'(lc_b[28]), 32'h62);
            check("lc_d14",    32'(lc_b[30]), 32'h66);
        end
        check("lc_done", 32'(bus2.done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
